// File: rtl/data_bus_responder.sv
// CPU data-port responder: data RAM plus a memory-mapped I/O page (output port, synchronised
// input port, output FIFO, and an optional compare timer built only when DBR_TIMER_EN is defined).
module data_bus_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_we,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [DATA_WIDTH-1:0] o_port,
  input  logic [DATA_WIDTH-1:0] i_port,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_fifo_valid,
  input  logic                  i_fifo_ready,
  output logic                  o_irq
);

  localparam int unsigned RAM_AW      = $clog2(RAM_DEPTH);
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [ADDR_WIDTH-1:0] IO_BASE   = ADDR_WIDTH'(12'hF00);
  localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_OUT   = 4'h0;
  localparam logic [3:0] OFF_IN    = 4'h1;
  localparam logic [3:0] OFF_FDATA = 4'h2;
  localparam logic [3:0] OFF_FSTAT = 4'h3;
`ifdef DBR_TIMER_EN
  localparam logic [3:0] OFF_TCNT  = 4'h4;
  localparam logic [3:0] OFF_TCMP  = 4'h5;
  localparam logic [3:0] OFF_TFLAG = 4'h6;
`endif

  // ---------------------------------------------------------------- decode
  logic       is_io;
  logic [3:0] io_off;
  logic       io_we;
  logic       ram_we;

  always_comb begin
    is_io  = (i_addr >= IO_BASE);
    io_off = i_addr[3:0];
    io_we  = i_we && is_io;
    ram_we = i_we && !is_io;
  end

  // ---------------------------------------------------------------- data RAM
  // Read is asynchronous because the CPU consumes ram_din in the same cycle.
  logic [DATA_WIDTH-1:0] ram_mem [RAM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      ram_mem[i_addr[RAM_AW-1:0]] <= i_wdata;
    end
  end

  // ---------------------------------------------------------------- output port
  logic [DATA_WIDTH-1:0] port_reg;
  logic [DATA_WIDTH-1:0] port_next;

  always_comb begin
    port_next = port_reg;
    if (io_we && io_off == OFF_OUT) begin
      port_next = i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      port_reg <= '0;
    end else begin
      port_reg <= port_next;
    end
  end

  assign o_port = port_reg;

  // ---------------------------------------------------------------- input synchroniser
  logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= i_port;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- output FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;

  always_comb begin
    fifo_valid    = (count_reg != '0);
    fifo_full     = (count_reg == FIFO_FULL);
    push_req      = io_we && io_off == OFF_FDATA;
    pop           = fifo_valid && i_fifo_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok       = push_req && (!fifo_full || pop);
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_next = count_reg - CNT_W'(1);
    end
    if (push_req && !push_ok) begin
      overflow_next = 1'b1;
    end else if (io_we && io_off == OFF_FSTAT && i_wdata[DATA_WIDTH-1]) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_rst) begin
      fifo_mem[wr_ptr_reg] <= i_wdata;
    end
  end

  assign o_fifo_data  = fifo_mem[rd_ptr_reg];
  assign o_fifo_valid = fifo_valid;

  logic [DATA_WIDTH-1:0] fstat;

  always_comb begin
    fstat               = '0;
    fstat[DATA_WIDTH-1] = overflow_reg;
    fstat[DATA_WIDTH-2] = fifo_full;
    fstat[DATA_WIDTH-3] = !fifo_valid;
    fstat[CNT_W-1:0]    = count_reg;
  end

  // ---------------------------------------------------------------- compare timer
`ifdef DBR_TIMER_EN
  logic [DATA_WIDTH-1:0] tcnt_reg, tcnt_next;
  logic [DATA_WIDTH-1:0] tcmp_reg, tcmp_next;
  logic                  flag_reg, flag_next;

  always_comb begin
    tcnt_next = tcnt_reg + DATA_WIDTH'(1);
    tcmp_next = tcmp_reg;
    flag_next = flag_reg;
    if (io_we && io_off == OFF_TCNT) begin
      tcnt_next = i_wdata;
    end
    if (io_we && io_off == OFF_TCMP) begin
      tcmp_next = i_wdata;
    end
    // Match uses the pre-write registers, and a match beats a same-cycle clear.
    if (tcnt_reg == tcmp_reg) begin
      flag_next = 1'b1;
    end else if (io_we && io_off == OFF_TFLAG && i_wdata[0]) begin
      flag_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcnt_reg <= '0;
      tcmp_reg <= '1;
      flag_reg <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      tcmp_reg <= tcmp_next;
      flag_reg <= flag_next;
    end
  end

  assign o_irq = flag_reg;
`else
  assign o_irq = 1'b0;
`endif

  // ---------------------------------------------------------------- read mux
  always_comb begin
    o_rdata = '0;
    if (!is_io) begin
      o_rdata = ram_mem[i_addr[RAM_AW-1:0]];
    end else begin
      case (io_off)
        OFF_OUT:   o_rdata = port_reg;
        OFF_IN:    o_rdata = sync_reg[SYNC_STAGES-1];
        OFF_FDATA: o_rdata = fifo_mem[rd_ptr_reg];
        OFF_FSTAT: o_rdata = fstat;
`ifdef DBR_TIMER_EN
        OFF_TCNT:  o_rdata = tcnt_reg;
        OFF_TCMP:  o_rdata = tcmp_reg;
        OFF_TFLAG: o_rdata = {{(DATA_WIDTH-1){1'b0}}, flag_reg};
`endif
        default:   o_rdata = '0;
      endcase
    end
  end

endmodule
